// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path constants: default widths, reset PC and FSM encodings.
// Imported by the fetch unit, the IR and the control unit.
package instr_fetch_unit_pkg;

    localparam int          ADDR_W_DEF   = 16;
    localparam int          DATA_W_DEF   = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_ERROR  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load beats increment, increment wraps.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            r_pc <= load_val;
        end else if (inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues instruction-memory reads and strobes the result
// into the IR, with timeout detection and a sticky halt.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              halt,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic              im_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic              ir_wr,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic              busy,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_im_req;
    logic [ADDR_W-1:0] r_im_addr;
    logic [DATA_W-1:0] r_ir_data;
    logic              r_ir_wr;
    logic              r_err;
    logic              r_busy;

    logic [2:0]        w_nxt;
    logic              w_ready;
    logic              w_load;
    logic              w_inc;
    logic [ADDR_W-1:0] w_pc;

    // IDLE and ERROR both accept new CU commands
    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_ERROR);
    assign w_load  = w_ready && pc_load && !halt;
    assign w_inc   = (r_state == ST_WRITE);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (fetch_start) w_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (im_valid)
                    w_nxt = ST_WRITE;
                else if (r_cnt == CW'(TIMEOUT - 1))
                    w_nxt = ST_ERROR;
            end
            ST_WRITE:  w_nxt = ST_IDLE;
            ST_HALTED: w_nxt = ST_HALTED;
            default:   w_nxt = ST_IDLE;
        endcase
        if (halt) w_nxt = ST_HALTED;
    end

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_load),
        .load_val (pc_load_val),
        .inc      (w_inc),
        .pc       (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_im_req  <= 1'b0;
            r_im_addr <= '0;
            r_ir_data <= '0;
            r_ir_wr   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_im_req <= (w_nxt == ST_FETCH);
            r_ir_wr  <= (w_nxt == ST_WRITE);
            r_busy   <= (w_nxt == ST_FETCH) || (w_nxt == ST_WRITE);
            if (r_state == ST_FETCH && w_nxt == ST_FETCH)
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
            if (w_ready && w_nxt == ST_FETCH)
                r_im_addr <= pc_load ? pc_load_val : w_pc;
            if (r_state == ST_FETCH && w_nxt == ST_WRITE)
                r_ir_data <= im_rdata;
            if (r_state == ST_FETCH && w_nxt == ST_ERROR)
                r_err <= 1'b1;
            else if (w_nxt == ST_FETCH)
                r_err <= 1'b0;
        end
    end

    assign im_req     = r_im_req;
    assign im_addr    = r_im_addr;
    assign ir_data    = r_ir_data;
    assign ir_wr      = r_ir_wr;
    assign fetch_done = r_ir_wr;
    assign fetch_err  = r_err;
    assign busy       = r_busy;
    assign pc_out     = w_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised transaction-level bench for instr_fetch_unit against a
// PC/latency reference model.
module tb_instr_fetch_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = '0;
    logic        halt = 1'b0;
    logic        im_req;
    logic [15:0] im_addr;
    logic [15:0] im_rdata = '0;
    logic        im_valid = 1'b0;
    logic [15:0] ir_data;
    logic        ir_wr;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;
    logic [15:0] pc_out;

    int n_vec = 0;
    int n_bad = 0;
    int pc_m  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .halt        (halt),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .im_valid    (im_valid),
        .ir_data     (ir_data),
        .ir_wr       (ir_wr),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err),
        .busy        (busy),
        .pc_out      (pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_im_req", 32'(im_req), 0);
        chk("rst_im_addr", 32'(im_addr), 0);
        chk("rst_ir_data", 32'(ir_data), 0);
        chk("rst_ir_wr", 32'(ir_wr), 0);
        chk("rst_done", 32'(fetch_done), 0);
        chk("rst_err", 32'(fetch_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", 32'(pc_out), 0);
    endtask

    task automatic load_only(input logic [15:0] v);
        @(negedge clk);
        pc_load = 1'b1;
        pc_load_val = v;
        @(negedge clk);
        pc_load = 1'b0;
        pc_m = int'(v);
        chk("load_pc", 32'(pc_out), 32'(pc_m));
        chk("load_busy", 32'(busy), 0);
    endtask

    // One fetch: memory answers on request cycle dly+1 (never if too late)
    task automatic fetch_txn(input bit ld, input logic [15:0] ldv,
                             input int dly, input logic [15:0] dat);
        int req_n = 0, wr_n = 0, wr_at = -1;
        int bad_addr = 0, bad_busy = 0, bad_done = 0;
        bit ok, ended = 0;
        int exp_req;
        @(negedge clk);
        fetch_start = 1'b1;
        pc_load = ld;
        pc_load_val = ldv;
        if (ld) pc_m = int'(ldv);
        ok = (dly + 1 <= TO);
        exp_req = ok ? dly + 1 : TO;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (im_req) begin
                req_n++;
                if (im_addr !== 16'(pc_m)) bad_addr++;
            end
            if (ir_wr) begin
                wr_n++;
                wr_at = cyc;
                chk("ir_data", 32'(ir_data), 32'(dat));
            end
            if (ir_wr !== fetch_done) bad_done++;
            if (busy !== (im_req || ir_wr)) bad_busy++;
            if (!busy) begin
                ended = 1;
                break;
            end
            im_valid = im_req && (req_n == dly + 1);
            im_rdata = im_valid ? dat : 16'($urandom);
            // noise that must be ignored while busy
            fetch_start = 1'($urandom);
            pc_load = 1'($urandom);
            pc_load_val = 16'($urandom);
        end
        fetch_start = 1'b0;
        pc_load = 1'b0;
        im_valid = 1'b0;
        chk("txn_bound", 32'(ended), 1);
        chk("req_cycles", 32'(req_n), 32'(exp_req));
        chk("addr_stable", 32'(bad_addr), 0);
        chk("busy_match", 32'(bad_busy), 0);
        chk("done_eq_wr", 32'(bad_done), 0);
        chk("wr_pulses", 32'(wr_n), ok ? 1 : 0);
        chk("fetch_err", 32'(fetch_err), ok ? 0 : 1);
        if (ok) begin
            chk("wr_latency", 32'(wr_at), 32'(dly + 1));
            pc_m = (pc_m + 1) % 65536;
        end
        chk("pc_after", 32'(pc_out), 32'(pc_m));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk_reset_outs();

        fetch_txn(0, 16'h0, 0, 16'hA5C3);
        fetch_txn(0, 16'h0, 3, 16'h1234);
        fetch_txn(1, 16'hFFFF, 0, 16'h5A5A);
        fetch_txn(0, 16'h0, TO + 5, 16'hDEAD);
        fetch_txn(0, 16'h0, 1, 16'hBEEF);
        fetch_txn(0, 16'h0, TO - 1, 16'h0F0F);
        fetch_txn(0, 16'h0, TO, 16'hF0F0);
        load_only(16'h0100);
        fetch_txn(0, 16'h0, 2, 16'h7777);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0)
                load_only(16'($urandom));
            fetch_txn(($urandom_range(0, 3) == 0), 16'($urandom),
                      $urandom_range(0, TO + 2), 16'($urandom));
        end

        // halt mid-fetch with a silent memory
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        chk("h_req_on", 32'(im_req), 1);
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("h_req_off", 32'(im_req), 0);
        chk("h_busy", 32'(busy), 0);
        chk("h_pc", 32'(pc_out), 32'(pc_m));
        for (int i = 0; i < 4; i++) begin
            fetch_start = 1'b1;
            pc_load = 1'b1;
            pc_load_val = 16'($urandom);
            im_valid = 1'b1;
            @(negedge clk);
            chk("h_ign_req", 32'(im_req), 0);
            chk("h_ign_wr", 32'(ir_wr), 0);
            chk("h_ign_pc", 32'(pc_out), 32'(pc_m));
        end
        fetch_start = 1'b0;
        pc_load = 1'b0;
        im_valid = 1'b0;

        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_reset_outs();
        pc_m = 0;
        fetch_txn(0, 16'h0, 0, 16'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
